// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_STARVE_MAX = 4;
    localparam int STARVE_W       = 4;

    typedef enum logic [0:0] {
        D_IDLE = 1'b0,
        D_ACK  = 1'b1
    } dbg_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Shares dmem between the core memory stage (default owner, zero latency) and a debug req/ack port.
// Debug loses at most STARVE_MAX contended cycles, then the core is stalled for exactly one cycle.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    dbg_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [DATA_W-1:0]   dbg_rdata_q;
    logic                dbg_elig;
    logic                dbg_gnt;

    // Grant depends only on requests and registered state, never on read data.
    always_comb begin
        dbg_elig = dbg_req && (state_q == D_IDLE);
        dbg_gnt  = dbg_elig && (!cpu_req || (starve_q >= STARVE_LIM));
        state_d  = dbg_gnt ? D_ACK : D_IDLE;
        if (dbg_elig && cpu_req && !dbg_gnt) begin
            starve_d = starve_q + STARVE_W'(1);
        end else begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= D_IDLE;
            starve_q    <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (dbg_gnt) begin
                dbg_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_stall = dbg_gnt && cpu_req;
    assign cpu_rdata = mem_rdata;
    assign dbg_ack   = (state_q == D_ACK);
    assign dbg_rdata = dbg_rdata_q;
    assign mem_addr  = dbg_gnt ? dbg_addr  : cpu_addr;
    assign mem_wdata = dbg_gnt ? dbg_wdata : cpu_wdata;
    assign mem_we    = dbg_gnt ? dbg_we    : (cpu_req && cpu_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized checks of dmem_arbiter against a transaction-level memory and arbitration model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Behavioural dmem: combinational read, write on the rising edge.
    logic          clr_mem;
    logic [DW-1:0] dmem [0:63];
    assign mem_rdata = dmem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int k = 0; k < 64; k++) dmem[k] <= '0;
        end else if (mem_we) begin
            dmem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] ref_mem [0:63];
    bit            m_ack;
    int            m_loss;
    logic [DW-1:0] m_rdata;
    int            cyc = 0;
    bit            last_stall;
    logic          obs_stall, obs_ack;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven (just after a falling edge).
    task automatic step();
        bit            elig, gnt;
        logic [AW-1:0] exp_addr;
        logic          exp_we;
        #2;
        elig     = dbg_req && !m_ack;
        gnt      = elig && (!cpu_req || m_loss == SMAX);
        exp_addr = gnt ? dbg_addr : cpu_addr;
        exp_we   = gnt ? dbg_we : (cpu_req && cpu_we);
        obs_stall = cpu_stall;
        obs_ack   = dbg_ack;
        chk1("cpu_stall", cpu_stall, gnt && cpu_req);
        chk1("dbg_ack", dbg_ack, m_ack);
        if (m_ack) chk32("dbg_rdata", dbg_rdata, m_rdata);
        chk1("mem_we", mem_we, exp_we);
        chk32("mem_addr", mem_addr, exp_addr);
        if (exp_we) chk32("mem_wdata", mem_wdata, gnt ? dbg_wdata : cpu_wdata);
        if (!gnt && cpu_req && !cpu_we) chk32("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:2]]);
        last_stall = gnt && cpu_req;
        @(posedge clk);
        if (gnt) begin
            m_rdata = ref_mem[dbg_addr[7:2]];
            if (dbg_we) ref_mem[dbg_addr[7:2]] = dbg_wdata;
        end else if (cpu_req && cpu_we) begin
            ref_mem[cpu_addr[7:2]] = cpu_wdata;
        end
        m_loss = (elig && cpu_req && !gnt) ? m_loss + 1 : 0;
        m_ack  = gnt;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        logic [6:0] smask, amask;
        logic [4:0] amask5;
        logic [1:0] amask2;
        int         ops, lat, dbg_start;
        bit         dbg_busy;

        rst = 1'b0; clr_mem = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        for (int k = 0; k < 64; k++) ref_mem[k] = '0;
        m_ack = 1'b0; m_loss = 0; m_rdata = '0; last_stall = 1'b0;

        #1;
        chk1("rst_dbg_ack", dbg_ack, 1'b0);
        chk32("rst_dbg_rdata", dbg_rdata, 32'h0);
        chk1("rst_cpu_stall", cpu_stall, 1'b0);
        chk1("rst_mem_we_idle", mem_we, 1'b0);
        cpu_req = 1'b1; cpu_we = 1'b1;
        #1;
        chk1("rst_mem_we_cpu_store", mem_we, 1'b1);
        cpu_req = 1'b0; cpu_we = 1'b0;
        @(negedge clk); @(negedge clk);
        clr_mem = 1'b0; rst = 1'b1;

        // CPU store, no debug traffic
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h11;
        step();
        chk1("store_no_ack", obs_ack, 1'b0);

        // Debug read with CPU idle
        cpu_req = 1'b0; cpu_we = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        step();
        dbg_req = 1'b0;
        step();
        chk1("rd_ack_pulse", obs_ack, 1'b1);
        chk32("rd_data_0x20", dbg_rdata, 32'h11);
        step();
        chk1("rd_ack_once", obs_ack, 1'b0);

        // Starvation: CPU busy every cycle, debug write forced through
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h24; dbg_wdata = 32'hAB;
        for (int i = 0; i < 7; i++) begin
            if (m_ack) dbg_req = 1'b0;
            step();
            smask[i] = obs_stall;
            amask[i] = obs_ack;
        end
        chk32("starve_stall_pattern", {25'b0, smask}, 32'b0010000);
        chk32("starve_ack_pattern", {25'b0, amask}, 32'b0100000);
        chk32("starve_write_landed", dmem[9], 32'hAB);

        // Held request, CPU idle: one transaction every two cycles
        cpu_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h24;
        for (int i = 0; i < 5; i++) begin
            step();
            amask5[i] = obs_ack;
        end
        chk32("held_ack_pattern", {27'b0, amask5}, 32'b01010);
        dbg_req = 1'b0;
        step();
        chk32("held_rd_data", dbg_rdata, 32'hAB);

        // Reset in the middle of an ack cycle
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        step();
        chk1("pre_rst_ack", dbg_ack, 1'b1);
        rst = 1'b0;
        #1;
        chk1("rst_drops_ack", dbg_ack, 1'b0);
        chk1("rst_clears_starve", dut.starve_q == '0, 1'b1);
        chk32("rst_clears_rdata", dbg_rdata, 32'h0);
        m_ack = 1'b0; m_loss = 0; m_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            amask2[i] = obs_ack;
        end
        chk32("post_rst_reack", {30'b0, amask2}, 32'b10);
        dbg_req = 1'b0;
        step();

        // Random interleave
        ops = 0; dbg_busy = 1'b0; dbg_start = 0;
        while (ops < 200 && cyc < 4000) begin
            if (m_ack) begin
                lat = cyc - dbg_start;
                chk1("dbg_latency_bound", (lat >= 1) && (lat <= SMAX + 1), 1'b1);
                dbg_req = 1'b0; dbg_busy = 1'b0; ops++;
            end else if (!dbg_busy && $urandom_range(0, 2) == 0) begin
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = 32'($urandom_range(0, 15)) << 2;
                dbg_wdata = $urandom;
                dbg_busy  = 1'b1;
                dbg_start = cyc;
            end
            if (!last_stall) begin
                cpu_req   = ($urandom_range(0, 3) != 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 32'($urandom_range(0, 15)) << 2;
                cpu_wdata = $urandom;
                if (cpu_req) ops++;
            end
            step();
        end
        chk1("random_ops_done", ops >= 200, 1'b1);
        for (int k = 0; k < 16; k++) chk32("final_mem", dmem[k], ref_mem[k]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port arbiter that shares the data memory between the pipelined ARM core's memory stage and a debug/DMA requester port. It sits between the processor's memory-stage signals and `dmem` in the top-level. The CPU is the default owner with zero added latency. The debug port uses a req/ack handshake, and a starvation counter guarantees it forward progress by stalling the CPU for one cycle when required.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_MAX`, 4, consecutive cycles a pending debug request may lose to the CPU before it is forced through (legal range 1..15)

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cpu_req`  in  1  memory-stage access valid (load or store)
- `cpu_we`  in  1  memory-stage store
- `cpu_addr`  in  ADDR_W  memory-stage address
- `cpu_wdata`  in  DATA_W  memory-stage store data
- `cpu_rdata`  out  DATA_W  load data to the core, combinational from `mem_rdata`
- `cpu_stall`  out  1  core must hold its memory stage this cycle
- `dbg_req`  in  1  debug request, held until `dbg_ack`
- `dbg_we`  in  1  debug write
- `dbg_addr`  in  ADDR_W  debug address, stable while `dbg_req` is high
- `dbg_wdata`  in  DATA_W  debug write data, stable while `dbg_req` is high
- `dbg_ack`  out  1  one-cycle completion pulse
- `dbg_rdata`  out  DATA_W  registered read data, valid while `dbg_ack`=1
- `mem_we`  out  1  to `dmem` `wr_en`
- `mem_addr`  out  ADDR_W  to `dmem` `addr`
- `mem_wdata`  out  DATA_W  to `dmem` `wr_data`
- `mem_rdata`  in  DATA_W  from `dmem` `rd_data`; combinational read

## Operation
- The debug FSM has two states:
  - `D_IDLE`: debug is eligible when `dbg_req`=1.
  - `D_ACK`: entered the cycle after a debug grant. `dbg_ack`=1 and debug is ineligible. Always returns to `D_IDLE` next cycle.
- Grant is combinational each cycle from the inputs and the registered state:
  - Debug not eligible or not requesting: CPU granted; `cpu_stall`=0.
  - Debug eligible, `cpu_req`=0: debug granted.
  - Both requesting, `starve_cnt` < `STARVE_MAX`: CPU granted; `starve_cnt` increments.
  - Both requesting, `starve_cnt` == `STARVE_MAX`: debug granted; `cpu_stall`=1.
- `starve_cnt` clears on any debug grant and on any cycle with debug not eligible or not requesting. It never exceeds `STARVE_MAX` (saturating compare).
- Mux:
  - Granted side drives `mem_addr`/`mem_wdata`.
  - `mem_we` = granted side's we AND its req.
  - With no requester, `mem_addr`=`cpu_addr` and `mem_we`=0.
- `cpu_rdata` = `mem_rdata` at all times. It is meaningful only when the CPU is granted.
- On a debug grant, `dbg_rdata` <= `mem_rdata` at the rising edge. For writes the captured value is don't-care but still captured.
- The requester may hold `dbg_req` through the `D_ACK` cycle. A request still high in the cycle after `D_ACK` is a new transaction.

## Timing
- CPU access: 0 added cycles when granted. A stall lasts exactly 1 cycle, after which the CPU wins because `starve_cnt` is cleared.
- Debug latency from `dbg_req` rise to `dbg_ack`:
  - Minimum 1 cycle (CPU idle).
  - Worst case `STARVE_MAX`+1 cycles.
- Debug write commits on the grant edge. `dbg_ack` follows one cycle later.
- Back-to-back debug transactions: one every 2 cycles maximum.
- Reset values: state=`D_IDLE`, `starve_cnt`=0, `dbg_ack`=0, `dbg_rdata`=0. Combinational outputs follow the idle mux: `mem_we`=0 unless `cpu_req`&`cpu_we`, and `cpu_stall`=0.
- Reset asserted mid-`D_ACK` drops the ack immediately. A write already committed stays committed. A still-held `dbg_req` is re-served after reset release.
- `cpu_stall` must not depend on `cpu_rdata`/`mem_rdata` (no combinational loop through the core).

## Structure
- `dmem_arb_pkg`: debug state enum (`D_IDLE`, `D_ACK`) and default width constants.
- Single module. No sub-module is needed; the starvation counter and FSM are a few flops each.
- Top-level inserts `dmem_arbiter` between the core's memory-stage signals and `dmem`. `cpu_stall` ORs into the hazard unit's stall/flush logic.

## Test plan
- Reset, then CPU store addr 0x20 data 0x11 with `dbg_req`=0 -> `mem_we`=1 same cycle, `cpu_stall`=0, `dbg_ack` stays 0.
- CPU idle, debug read addr 0x20 -> `dbg_ack` pulses 1 cycle later with `dbg_rdata`=0x11; FSM passes through `D_ACK` exactly once.
- `cpu_req` held high continuously plus debug write addr 0x24 data 0xAB, `STARVE_MAX`=4 -> 4 CPU-granted cycles, then `cpu_stall`=1 for one cycle with `mem_addr`=0x24 and `mem_we`=1, then `dbg_ack`; the CPU stalls no further.
- `dbg_req` held high for 5 cycles with CPU idle -> acks on cycles 2 and 4 (two transactions), never on consecutive cycles.
- Assert `rst`=0 during `D_ACK` -> `dbg_ack` drops asynchronously and `starve_cnt`=0; after release, the held request is acked again within 2 cycles.
- Random interleave of 200 CPU/debug ops against a reference memory model -> all reads match, no debug wait exceeds `STARVE_MAX`+1 cycles, no double commit.
